prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter NCH, 2, number of target memories (channel 0 = program, 1 = data); SHALL be 1..8.
REQ-002 Parameter AW, 20, word-address width of each memory load port.
REQ-003 Parameter DW, 32, data width.
REQ-004 Parameter PAD_WORDS, 3, zero words written after every accepted word of channel 0; SHALL be 0..7.
REQ-005 Parameter CNT_W, 32, cycle-counter width.
REQ-006 CLK  in  1  single clock, all state on rising edge.
REQ-007 RST  in  1  asynchronous, active-high reset.
REQ-008 GO  in  1  pulse: start a load session from IDLE.
REQ-009 IN_VALID  in  1; IN_READY  out  1; IN_CHAN  in  3; IN_DATA  in  DW; IN_LAST  in  1: word stream, transfer when VALID&READY.
REQ-010 LOAD_CTRL  out  NCH  one-hot memory write strobe; LOAD_ADDR  out  AW; LOAD_DATA  out  DW.
REQ-011 CORE_RSTn  out  1; CORE_EN  out  1; CORE_START  out  1: core control.
REQ-012 OK  in  1  core completion flag.
REQ-013 BUSY  out  1; DONE  out  1; ERR  out  1  sticky status.
REQ-014 CYCLES  out  CNT_W  core run-cycle count (only with macro, see REQ-033).

Function
REQ-015 FSM states: IDLE, LOAD, PAD, RELEASE, RUN, FIN, FAULT.
REQ-016 IDLE->LOAD on GO; per-channel address counters and done flags cleared on entry.
REQ-017 LOAD: IN_READY=1 iff state is LOAD; every transfer drives LOAD_CTRL[IN_CHAN]=1, LOAD_ADDR=addr[IN_CHAN], LOAD_DATA=IN_DATA for exactly one cycle (registered, 1-cycle latency from handshake), then addr[IN_CHAN]+1.
REQ-018 Transfer on channel 0 with PAD_WORDS>0 -> PAD: PAD_WORDS consecutive cycles of LOAD_CTRL[0]=1, LOAD_DATA=0, incrementing addresses; IN_READY=0; then back to LOAD (or RELEASE per REQ-020).
REQ-019 IN_LAST with a transfer sets done[IN_CHAN] after the word and its padding are written.
REQ-020 All done flags set -> RELEASE for exactly 1 cycle (CORE_RSTn still 0, no strobes), then RUN.
REQ-021 RUN: CORE_RSTn=1, CORE_EN=1, CORE_START=1 held; OK=1 -> FIN.
REQ-022 FIN: DONE=1, CORE_EN=0, CORE_START=0, CORE_RSTn=1; stays until RST; GO ignored.
REQ-023 BUSY=1 in LOAD, PAD, RELEASE, RUN.
REQ-024 Faults -> FAULT, ERR=1: IN_CHAN>=NCH; transfer on a channel already done; write with addr[ch] = 2^AW-1 already used (no wrap; word dropped). FAULT: IN_READY=0, no strobes, CORE_RSTn=0; exit only by RST.
REQ-025 GO while not IDLE ignored; IN_VALID outside LOAD ignored, no strobe.
REQ-026 Never more than one LOAD_CTRL bit high; LOAD_CTRL=0 whenever no write.
REQ-027 OK sampled only in RUN; OK high in RELEASE has no effect.

Reset
REQ-028 RST asserted (any state, incl. mid-load or mid-run) -> IDLE immediately, asynchronously.
REQ-029 Reset values: IN_READY=0, LOAD_CTRL=0, LOAD_ADDR=0, LOAD_DATA=0, CORE_RSTn=0, CORE_EN=0, CORE_START=0, BUSY=0, DONE=0, ERR=0, CYCLES=0.
REQ-030 Core held in reset (CORE_RSTn=0) in IDLE, LOAD, PAD, RELEASE, FAULT.

Configuration
REQ-031 Macro PROG_LOADER_CYCLE_CNT_EN.
REQ-032 Defined: CYCLES counts every RUN cycle, cleared on LOAD entry, frozen in FIN; saturates at 2^CNT_W-1.
REQ-033 Undefined: counter absent, CYCLES port present and tied 0; all other behaviour identical.

Verification
REQ-034 NCH=2, PAD_WORDS=3: ch0 words 0x00500093,0x00100113(last), ch1 0xDEADBEEF(last) -> ch0 writes addr0..7 = w0,0,0,0,w1,0,0,0; ch1 addr0=0xDEADBEEF; one RELEASE cycle then CORE_RSTn=1.
REQ-035 Macro on: OK raised on 10th RUN cycle -> CYCLES=10, DONE=1, CORE_EN=0 next cycle.
REQ-036 IN_CHAN=5 with NCH=2 -> ERR=1, FAULT, no strobe, IN_READY=0 until RST.
REQ-037 RST pulse during PAD -> all outputs at reset values same cycle; new GO reloads from addr 0.
REQ-038 AW=2, PAD_WORDS=0: fifth ch0 word -> dropped, ERR=1; ch1 second IN_LAST -> ERR=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Word-stream input and memory load bus of prog_loader.
// The slave modport is the loader side. The master modport is the producer and memory side.
interface prog_loader_if #(
    parameter int NCH = 2,
    parameter int AW  = 20,
    parameter int DW  = 32
);
    logic           IN_VALID;
    logic           IN_READY;
    logic [2:0]     IN_CHAN;
    logic [DW-1:0]  IN_DATA;
    logic           IN_LAST;
    logic [NCH-1:0] LOAD_CTRL;
    logic [AW-1:0]  LOAD_ADDR;
    logic [DW-1:0]  LOAD_DATA;

    modport master (
        output IN_VALID, IN_CHAN, IN_DATA, IN_LAST,
        input  IN_READY, LOAD_CTRL, LOAD_ADDR, LOAD_DATA
    );

    modport slave (
        input  IN_VALID, IN_CHAN, IN_DATA, IN_LAST,
        output IN_READY, LOAD_CTRL, LOAD_ADDR, LOAD_DATA
    );
endinterface

// File: rtl/prog_loader.sv
// Program/data memory loader with core release sequencing and sticky status.
// Optional run-cycle counter is enabled by defining PROG_LOADER_CYCLE_CNT_EN.
module prog_loader #(
    parameter int NCH       = 2,
    parameter int AW        = 20,
    parameter int DW        = 32,
    parameter int PAD_WORDS = 3,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GO,
    prog_loader_if.slave     bus,
    output logic             CORE_RSTn,
    output logic             CORE_EN,
    output logic             CORE_START,
    input  logic             OK,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] CYCLES
);

    localparam int unsigned NCH_U = NCH;
    localparam logic [3:0]  NCH4  = 4'(NCH);
    localparam logic [2:0]  PAD3  = 3'(PAD_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_RELEASE,
        S_RUN,
        S_FIN,
        S_FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q [NCH];
    logic [AW-1:0]  addr_d [NCH];
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] full_q, full_d;
    logic [2:0]     pad_cnt_q, pad_cnt_d;
    logic           pad_last_q, pad_last_d;
    logic [NCH-1:0] ctrl_q, ctrl_d;
    logic [AW-1:0]  laddr_q, laddr_d;
    logic [DW-1:0]  ldata_q, ldata_d;

    logic           chan_ok;
    logic [AW-1:0]  sel_addr;
    logic           sel_done;
    logic           sel_full;
    logic [NCH-1:0] sel_hot;

    // Per-channel view of the requested channel; all zero when out of range.
    always_comb begin
        chan_ok  = ({1'b0, bus.IN_CHAN} < NCH4);
        sel_addr = '0;
        sel_done = 1'b0;
        sel_full = 1'b0;
        sel_hot  = '0;
        for (int unsigned c = 0; c < NCH_U; c++) begin
            if (32'(bus.IN_CHAN) == c) begin
                sel_addr   = addr_q[c];
                sel_done   = done_q[c];
                sel_full   = full_q[c];
                sel_hot[c] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        done_d     = done_q;
        full_d     = full_q;
        pad_cnt_d  = pad_cnt_q;
        pad_last_d = pad_last_q;
        ctrl_d     = '0;
        laddr_d    = laddr_q;
        ldata_d    = ldata_q;

        unique case (state_q)
            S_IDLE: begin
                if (GO) begin
                    state_d = S_LOAD;
                    for (int unsigned c = 0; c < NCH_U; c++) begin
                        addr_d[c] = '0;
                    end
                    done_d = '0;
                    full_d = '0;
                end
            end

            S_LOAD: begin
                if (bus.IN_VALID) begin
                    if (!chan_ok || sel_done || sel_full) begin
                        state_d = S_FAULT;
                    end else begin
                        ctrl_d  = sel_hot;
                        laddr_d = sel_addr;
                        ldata_d = bus.IN_DATA;
                        // The top address is usable once; afterwards the channel is full.
                        for (int unsigned c = 0; c < NCH_U; c++) begin
                            if (sel_hot[c]) begin
                                if (&sel_addr) full_d[c] = 1'b1;
                                else           addr_d[c] = sel_addr + AW'(1);
                            end
                        end
                        if (bus.IN_CHAN == 3'd0 && PAD_WORDS > 0) begin
                            state_d    = S_PAD;
                            pad_cnt_d  = PAD3;
                            pad_last_d = bus.IN_LAST;
                        end else if (bus.IN_LAST) begin
                            done_d = done_q | sel_hot;
                        end
                    end
                end else if (&done_q) begin
                    // Entered one cycle after the final strobe so RELEASE carries none.
                    state_d = S_RELEASE;
                end
            end

            S_PAD: begin
                if (full_q[0]) begin
                    state_d = S_FAULT;
                end else begin
                    ctrl_d[0] = 1'b1;
                    laddr_d   = addr_q[0];
                    ldata_d   = '0;
                    if (&addr_q[0]) full_d[0] = 1'b1;
                    else            addr_d[0] = addr_q[0] + AW'(1);
                    pad_cnt_d = pad_cnt_q - 3'd1;
                    if (pad_cnt_q == 3'd1) begin
                        state_d = S_LOAD;
                        if (pad_last_q) done_d[0] = 1'b1;
                    end
                end
            end

            S_RELEASE: state_d = S_RUN;

            S_RUN: begin
                if (OK) state_d = S_FIN;
            end

            S_FIN:   state_d = S_FIN;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            for (int unsigned c = 0; c < NCH_U; c++) begin
                addr_q[c] <= '0;
            end
            done_q     <= '0;
            full_q     <= '0;
            pad_cnt_q  <= '0;
            pad_last_q <= 1'b0;
            ctrl_q     <= '0;
            laddr_q    <= '0;
            ldata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            full_q     <= full_d;
            pad_cnt_q  <= pad_cnt_d;
            pad_last_q <= pad_last_d;
            ctrl_q     <= ctrl_d;
            laddr_q    <= laddr_d;
            ldata_q    <= ldata_d;
        end
    end

`ifdef PROG_LOADER_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (state_q == S_IDLE && GO) begin
            cycles_d = '0;
        end else if (state_q == S_RUN && !(&cycles_q)) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cycles_q <= '0;
        else     cycles_q <= cycles_d;
    end

    assign CYCLES = cycles_q;
`else
    assign CYCLES = '0;
`endif

    assign bus.IN_READY  = (state_q == S_LOAD);
    assign bus.LOAD_CTRL = ctrl_q;
    assign bus.LOAD_ADDR = laddr_q;
    assign bus.LOAD_DATA = ldata_q;

    assign CORE_RSTn  = (state_q == S_RUN) || (state_q == S_FIN);
    assign CORE_EN    = (state_q == S_RUN);
    assign CORE_START = (state_q == S_RUN);
    assign BUSY       = (state_q == S_LOAD) || (state_q == S_PAD) ||
                        (state_q == S_RELEASE) || (state_q == S_RUN);
    assign DONE       = (state_q == S_FIN);
    assign ERR        = (state_q == S_FAULT);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: dut_a uses NCH=2/AW=20/PAD_WORDS=3, dut_b uses NCH=2/AW=2/PAD_WORDS=0.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go_a = 1'b0, go_b = 1'b0;
    logic ok_a = 1'b0, ok_b = 1'b0;
    logic core_rstn_a, core_en_a, core_start_a, busy_a, done_a, err_a;
    logic core_rstn_b, core_en_b, core_start_b, busy_b, done_b, err_b;
    logic [31:0] cycles_a, cycles_b;

    int passed = 0;
    int total  = 0;
    int multi_hot = 0;

`ifdef PROG_LOADER_CYCLE_CNT_EN
    localparam logic [31:0] EXP_CYC = 32'd10;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
`endif

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [19:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t log_a[$];
    wr_t log_b[$];

    prog_loader_if #(.NCH(2), .AW(20), .DW(32)) bus_a ();
    prog_loader_if #(.NCH(2), .AW(2),  .DW(32)) bus_b ();

    prog_loader #(.NCH(2), .AW(20), .DW(32), .PAD_WORDS(3), .CNT_W(32)) dut_a (
        .CLK(clk), .RST(rst), .GO(go_a), .bus(bus_a),
        .CORE_RSTn(core_rstn_a), .CORE_EN(core_en_a), .CORE_START(core_start_a),
        .OK(ok_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .CYCLES(cycles_a)
    );

    prog_loader #(.NCH(2), .AW(2), .DW(32), .PAD_WORDS(0), .CNT_W(32)) dut_b (
        .CLK(clk), .RST(rst), .GO(go_b), .bus(bus_b),
        .CORE_RSTn(core_rstn_b), .CORE_EN(core_en_b), .CORE_START(core_start_b),
        .OK(ok_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .CYCLES(cycles_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_a.LOAD_CTRL != 2'b00) log_a.push_back({bus_a.LOAD_CTRL, bus_a.LOAD_ADDR, bus_a.LOAD_DATA});
        if (bus_b.LOAD_CTRL != 2'b00) log_b.push_back({bus_b.LOAD_CTRL, 18'd0, bus_b.LOAD_ADDR, bus_b.LOAD_DATA});
        if ($countones(bus_a.LOAD_CTRL) > 1 || $countones(bus_b.LOAD_CTRL) > 1) multi_hot++;
    end

    task automatic send(input bit b, input logic [2:0] ch, input logic [31:0] d,
                        input logic last, output bit acc);
        acc = 1'b0;
        if (b) begin
            bus_b.IN_VALID = 1'b1; bus_b.IN_CHAN = ch; bus_b.IN_DATA = d; bus_b.IN_LAST = last;
        end else begin
            bus_a.IN_VALID = 1'b1; bus_a.IN_CHAN = ch; bus_a.IN_DATA = d; bus_a.IN_LAST = last;
        end
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = b ? bus_b.IN_READY : bus_a.IN_READY;
            @(negedge clk);
        end
        bus_a.IN_VALID = 1'b0;
        bus_b.IN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if ({bus_a.IN_READY, bus_a.LOAD_CTRL, bus_a.LOAD_ADDR, bus_a.LOAD_DATA} !== '0)
            $display("FAIL reset_bus_a: got %0h expected 0", {bus_a.IN_READY, bus_a.LOAD_CTRL, bus_a.LOAD_ADDR, bus_a.LOAD_DATA}); else passed++;
        total++; if ({core_rstn_a, core_en_a, core_start_a, busy_a, done_a, err_a} !== 6'b0)
            $display("FAIL reset_ctrl_a: got %b expected 000000", {core_rstn_a, core_en_a, core_start_a, busy_a, done_a, err_a}); else passed++;
        total++; if (cycles_a !== 32'd0) $display("FAIL reset_cycles_a: got %0d expected 0", cycles_a); else passed++;
        total++; if ({bus_b.IN_READY, bus_b.LOAD_CTRL, core_rstn_b, busy_b, done_b, err_b} !== 7'b0)
            $display("FAIL reset_b: got %b expected 0000000", {bus_b.IN_READY, bus_b.LOAD_CTRL, core_rstn_b, busy_b, done_b, err_b}); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        log_a.delete();
        bus_a.IN_VALID = 1'b1; bus_a.IN_CHAN = 3'd0; bus_a.IN_DATA = 32'h55; bus_a.IN_LAST = 1'b0;
        repeat (3) @(negedge clk);
        bus_a.IN_VALID = 1'b0;
        #1;
        total++; if ({bus_a.IN_READY, busy_a} !== 2'b00) $display("FAIL idle_ready_busy: got %b expected 00", {bus_a.IN_READY, busy_a}); else passed++;
        total++; if (log_a.size() !== 0) $display("FAIL idle_no_strobe: got %0d expected 0", log_a.size()); else passed++;
    endtask

    task automatic test_load_run();
        wr_t exp_w[9];
        bit  acc;
        int  rel_cnt = 0;
        bit  seen = 0;
        bit  en_bad = 0;
        exp_w[0] = {2'b01, 20'd0, 32'h00500093};
        exp_w[1] = {2'b01, 20'd1, 32'h0};
        exp_w[2] = {2'b01, 20'd2, 32'h0};
        exp_w[3] = {2'b01, 20'd3, 32'h0};
        exp_w[4] = {2'b01, 20'd4, 32'h00100113};
        exp_w[5] = {2'b01, 20'd5, 32'h0};
        exp_w[6] = {2'b01, 20'd6, 32'h0};
        exp_w[7] = {2'b01, 20'd7, 32'h0};
        exp_w[8] = {2'b10, 20'd0, 32'hDEADBEEF};
        log_a.delete();
        go_a = 1'b1; @(negedge clk); go_a = 1'b0;
        total++; if ({busy_a, bus_a.IN_READY, core_rstn_a} !== 3'b110) $display("FAIL load_entry: got %b expected 110", {busy_a, bus_a.IN_READY, core_rstn_a}); else passed++;
        send(1'b0, 3'd0, 32'h00500093, 1'b0, acc);
        total++; if (acc !== 1'b1) $display("FAIL load_w0_accept: got %b expected 1", acc); else passed++;
        total++; if (bus_a.IN_READY !== 1'b0) $display("FAIL pad_ready: got %b expected 0", bus_a.IN_READY); else passed++;
        send(1'b0, 3'd0, 32'h00100113, 1'b1, acc);
        total++; if (acc !== 1'b1) $display("FAIL load_w1_accept: got %b expected 1", acc); else passed++;
        send(1'b0, 3'd1, 32'hDEADBEEF, 1'b1, acc);
        total++; if (acc !== 1'b1) $display("FAIL load_ch1_accept: got %b expected 1", acc); else passed++;
        // Count RELEASE cycles (busy, core in reset, no ready, no strobe); pulse OK there.
        for (int k = 0; k < 20 && !seen; k++) begin
            if (core_rstn_a) begin
                seen = 1;
            end else begin
                if (busy_a && !bus_a.IN_READY && bus_a.LOAD_CTRL == 2'b00) begin
                    rel_cnt++;
                    ok_a = 1'b1;
                end else begin
                    ok_a = 1'b0;
                end
                @(negedge clk);
            end
        end
        ok_a = 1'b0;
        total++; if (seen !== 1'b1) $display("FAIL core_release_timeout: got %b expected 1", seen); else passed++;
        total++; if (rel_cnt !== 1) $display("FAIL release_cycles: got %0d expected 1", rel_cnt); else passed++;
        #1;
        total++; if (log_a.size() !== 9) $display("FAIL write_count: got %0d expected 9", log_a.size()); else passed++;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (i >= log_a.size()) $display("FAIL write_%0d: got none expected %h", i, exp_w[i]);
            else if (log_a[i] !== exp_w[i]) $display("FAIL write_%0d: got %h expected %h", i, log_a[i], exp_w[i]);
            else passed++;
        end
        for (int k = 1; k < 10; k++) begin
            if (!(core_en_a && core_start_a && core_rstn_a && busy_a) || done_a) en_bad = 1;
            @(negedge clk);
        end
        total++; if (en_bad !== 1'b0) $display("FAIL run_hold: got %b expected 0", en_bad); else passed++;
        total++; if ({core_en_a, done_a} !== 2'b10) $display("FAIL run_10th: got %b expected 10", {core_en_a, done_a}); else passed++;
        ok_a = 1'b1; @(negedge clk); ok_a = 1'b0;
        total++; if ({done_a, core_en_a, core_start_a, core_rstn_a, busy_a} !== 5'b10010)
            $display("FAIL fin_outputs: got %b expected 10010", {done_a, core_en_a, core_start_a, core_rstn_a, busy_a}); else passed++;
        total++; if (cycles_a !== EXP_CYC) $display("FAIL fin_cycles: got %0d expected %0d", cycles_a, EXP_CYC); else passed++;
        go_a = 1'b1; @(negedge clk); go_a = 1'b0; @(negedge clk);
        total++; if ({done_a, busy_a, bus_a.IN_READY} !== 3'b100) $display("FAIL fin_go_ignored: got %b expected 100", {done_a, busy_a, bus_a.IN_READY}); else passed++;
        total++; if (cycles_a !== EXP_CYC) $display("FAIL fin_cycles_frozen: got %0d expected %0d", cycles_a, EXP_CYC); else passed++;
    endtask

    task automatic test_fault_chan();
        bit acc;
        do_reset();
        log_a.delete();
        go_a = 1'b1; @(negedge clk); go_a = 1'b0;
        send(1'b0, 3'd5, 32'h12, 1'b0, acc);
        total++; if (acc !== 1'b1) $display("FAIL badchan_accept: got %b expected 1", acc); else passed++;
        total++; if ({err_a, bus_a.IN_READY, busy_a, core_rstn_a} !== 4'b1000)
            $display("FAIL badchan_fault: got %b expected 1000", {err_a, bus_a.IN_READY, busy_a, core_rstn_a}); else passed++;
        bus_a.IN_VALID = 1'b1; bus_a.IN_CHAN = 3'd0;
        go_a = 1'b1;
        repeat (3) @(negedge clk);
        bus_a.IN_VALID = 1'b0; go_a = 1'b0;
        #1;
        total++; if ({err_a, bus_a.IN_READY} !== 2'b10) $display("FAIL fault_sticky: got %b expected 10", {err_a, bus_a.IN_READY}); else passed++;
        total++; if (log_a.size() !== 0) $display("FAIL fault_no_strobe: got %0d expected 0", log_a.size()); else passed++;
    endtask

    task automatic test_reset_pad();
        bit acc;
        do_reset();
        log_a.delete();
        go_a = 1'b1; @(negedge clk); go_a = 1'b0;
        send(1'b0, 3'd0, 32'hA5A5A5A5, 1'b0, acc);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({bus_a.IN_READY, bus_a.LOAD_CTRL, bus_a.LOAD_ADDR, bus_a.LOAD_DATA, core_rstn_a, core_en_a, core_start_a, busy_a, done_a, err_a, cycles_a} !== '0)
            $display("FAIL pad_async_reset: got %0h expected 0", {bus_a.IN_READY, bus_a.LOAD_CTRL, bus_a.LOAD_ADDR, bus_a.LOAD_DATA, busy_a, err_a}); else passed++;
        total++; if (log_a.size() !== 2) $display("FAIL pad_pre_reset_writes: got %0d expected 2", log_a.size()); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        log_a.delete();
        go_a = 1'b1; @(negedge clk); go_a = 1'b0;
        send(1'b0, 3'd0, 32'h12345678, 1'b1, acc);
        send(1'b0, 3'd1, 32'h00000001, 1'b1, acc);
        repeat (2) @(negedge clk);
        #1;
        total++; if (log_a.size() !== 5) $display("FAIL reload_count: got %0d expected 5", log_a.size()); else passed++;
        total++;
        if (log_a.size() == 0) $display("FAIL reload_first: got none expected %h", {2'b01, 20'd0, 32'h12345678});
        else if (log_a[0] !== {2'b01, 20'd0, 32'h12345678}) $display("FAIL reload_first: got %h expected %h", log_a[0], {2'b01, 20'd0, 32'h12345678});
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit all_acc = 1;
        do_reset();
        log_b.delete();
        go_b = 1'b1; @(negedge clk); go_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 3'd0, 32'h10 + 32'(i), 1'b0, acc);
            if (!acc) all_acc = 0;
        end
        total++; if (all_acc !== 1'b1) $display("FAIL b2b_accept: got %b expected 1", all_acc); else passed++;
        total++; if (err_b !== 1'b0) $display("FAIL b2b_no_err: got %b expected 0", err_b); else passed++;
        send(1'b1, 3'd0, 32'h14, 1'b0, acc);
        #1;
        total++; if ({err_b, bus_b.IN_READY} !== 2'b10) $display("FAIL addr_full_err: got %b expected 10", {err_b, bus_b.IN_READY}); else passed++;
        total++; if (log_b.size() !== 4) $display("FAIL addr_full_dropped: got %0d expected 4", log_b.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= log_b.size()) $display("FAIL b2b_write_%0d: got none", i);
            else if (log_b[i] !== {2'b01, 20'(i), 32'h10 + 32'(i)}) $display("FAIL b2b_write_%0d: got %h expected %h", i, log_b[i], {2'b01, 20'(i), 32'h10 + 32'(i)});
            else passed++;
        end
        do_reset();
        log_b.delete();
        go_b = 1'b1; @(negedge clk); go_b = 1'b0;
        send(1'b1, 3'd1, 32'hAA, 1'b1, acc);
        total++; if (err_b !== 1'b0) $display("FAIL ch1_first_last: got %b expected 0", err_b); else passed++;
        send(1'b1, 3'd1, 32'hBB, 1'b1, acc);
        #1;
        total++; if ({err_b, busy_b} !== 2'b10) $display("FAIL ch1_done_again: got %b expected 10", {err_b, busy_b}); else passed++;
        total++; if (log_b.size() !== 1) $display("FAIL ch1_done_dropped: got %0d expected 1", log_b.size()); else passed++;
        total++; if (multi_hot !== 0) $display("FAIL onehot: got %0d expected 0", multi_hot); else passed++;
    endtask

    initial begin
        bus_a.IN_VALID = 1'b0; bus_a.IN_CHAN = 3'd0; bus_a.IN_DATA = '0; bus_a.IN_LAST = 1'b0;
        bus_b.IN_VALID = 1'b0; bus_b.IN_CHAN = 3'd0; bus_b.IN_DATA = '0; bus_b.IN_LAST = 1'b0;
        test_reset();
        test_idle_ignore();
        test_load_run();
        test_fault_chan();
        test_reset_pad();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
